// File: rtl/party_broadcast_packer.sv
// ============================================================================
// party_broadcast_packer
// ----------------------------------------------------------------------------
// Purpose:
//   Captures one party's broadcast shares (alpha, beta, v; T 32-bit elements
//   each) on the upstream done pulse. It then streams them as N_WORDS = 3*T
//   32-bit words over a valid/ready interface into the commitment hash
//   absorb front-end. Word order is alpha[0..T-1], beta[0..T-1], v[0..T-1].
//   Two sticky protocol flags are kept. The first reports a capture request
//   that was dropped while a stream was still in flight. The second
//   (P251 only) reports a captured byte that falls outside the field.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset (deassertion synchronised here)
//   i_start      capture pulse (upstream o_done)
//   i_alpha      alpha share, T x 32 bits, element 0 in the low word
//   i_beta       beta share,  T x 32 bits
//   i_v          v share,     T x 32 bits
//   i_clear      synchronous clear of the sticky error flags
//   o_data       stream word
//   o_valid      o_data valid
//   i_ready      sink accepts the current word
//   o_last       high with the final word of a capture
//   o_busy       capture held and not yet fully sent
//   o_done       one-cycle pulse after the final word transfers
//   o_overflow   sticky: i_start dropped while busy
//   o_range_err  sticky: byte >= 251 captured (P251 only)
// ============================================================================
module party_broadcast_packer #(
    parameter string FIELD         = "P251",
    parameter string PARAMETER_SET = "L5",
    parameter int    T             = (PARAMETER_SET == "L5") ? 4 : 3,
    parameter int    N_WORDS       = 3 * T
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [32*T-1:0]   i_alpha,
    input  logic [32*T-1:0]   i_beta,
    input  logic [32*T-1:0]   i_v,
    input  logic              i_clear,
    output logic [31:0]       o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic              o_range_err
);

    localparam int               CNT_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);
    localparam bit               IS_P251  = (FIELD == "P251");

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    // ------------------------------------------------------------------------
    // Reset conditioning: assertion propagates immediately, deassertion is
    // released two clock edges later so all state leaves reset in one cycle.
    // ------------------------------------------------------------------------
    logic r_rst_meta;
    logic r_rst_sync;
    logic w_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_cap [N_WORDS];
    logic             r_done;
    logic             r_overflow;
    logic             r_range_err;

    // ------------------------------------------------------------------------
    // Incoming shares flattened into stream order.
    // ------------------------------------------------------------------------
    logic [31:0] w_in_words [N_WORDS];

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path through the block can infer a latch.
    always_comb begin
        for (int w = 0; w < N_WORDS; w++) begin
            w_in_words[w] = '0;
        end
        for (int w = 0; w < T; w++) begin
            w_in_words[w]       = i_alpha[32*w +: 32];
            w_in_words[T + w]   = i_beta[32*w +: 32];
            w_in_words[2*T + w] = i_v[32*w +: 32];
        end
    end

    // Any byte of the capture at or above the P251 modulus is out of field.
    logic w_range_hit;

    always_comb begin
        w_range_hit = 1'b0;
        if (IS_P251) begin
            for (int w = 0; w < N_WORDS; w++) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_in_words[w][8*b +: 8] >= 8'd251) begin
                        w_range_hit = 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic w_xfer;
    logic w_final;
    logic w_accept;
    logic w_overflow_set;

    assign w_xfer         = (r_state == ST_SEND) & i_ready;
    assign w_final        = w_xfer & (r_cnt == LAST_IDX);
    // A start coinciding with the final transfer chains straight into a new
    // capture; any other start while sending is dropped and flagged.
    assign w_accept       = i_start & ((r_state == ST_IDLE) | w_final);
    assign w_overflow_set = i_start & (r_state == ST_SEND) & ~w_final;

    // ------------------------------------------------------------------------
    // FSM, capture register, counter and flags
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_range_err <= 1'b0;
            // NOTE: the capture bank is a handful of flops, not a RAM, so it
            // is reset to keep o_data deterministic out of reset.
            for (int w = 0; w < N_WORDS; w++) begin
                r_cap[w] <= '0;
            end
        end else begin
            r_done      <= w_final;
            // Set takes priority over a simultaneous clear.
            r_overflow  <= w_overflow_set | (r_overflow & ~i_clear);
            r_range_err <= (w_accept & w_range_hit) | (r_range_err & ~i_clear);

            if (w_accept) begin
                for (int w = 0; w < N_WORDS; w++) begin
                    r_cap[w] <= w_in_words[w];
                end
                r_cnt   <= '0;
                r_state <= ST_SEND;
            end else if (w_final) begin
                r_cnt   <= '0;
                r_state <= ST_IDLE;
            end else if (w_xfer) begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all derived from registers only; o_data is a word select of
    // the capture bank, so held stable whenever the counter is held.
    // ------------------------------------------------------------------------
    assign o_valid     = (r_state == ST_SEND);
    assign o_busy      = (r_state == ST_SEND);
    assign o_data      = (r_state == ST_SEND) ? r_cap[r_cnt] : '0;
    assign o_last      = (r_state == ST_SEND) & (r_cnt == LAST_IDX);
    assign o_done      = r_done;
    assign o_overflow  = r_overflow;
    assign o_range_err = r_range_err;

endmodule

// File: tb/tb_party_broadcast_packer.sv
// ============================================================================
// tb_party_broadcast_packer
// ----------------------------------------------------------------------------
// Drives two instances (P251 and GF256, both L5 / T=4) from shared stimulus.
// A queue-based reference model predicts every output each cycle. Literal
// expectations pin the directed scenarios: basic stream, backpressure,
// back-to-back capture, overflow, range check and mid-stream reset. These
// are followed by a randomized phase.
// ============================================================================
module tb_party_broadcast_packer;

    localparam int T  = 4;
    localparam int NW = 3 * T;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            clear = 1'b0;
    logic            ready = 1'b0;
    logic [32*T-1:0] alpha = '0;
    logic [32*T-1:0] beta  = '0;
    logic [32*T-1:0] v     = '0;

    logic [31:0] data_p,  data_g;
    logic        valid_p, valid_g;
    logic        last_p,  last_g;
    logic        busy_p,  busy_g;
    logic        done_p,  done_g;
    logic        ovf_p,   ovf_g;
    logic        rng_p,   rng_g;

    party_broadcast_packer #(.FIELD("P251"), .PARAMETER_SET("L5")) u_p251 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_alpha(alpha), .i_beta(beta), .i_v(v), .i_clear(clear),
        .o_data(data_p), .o_valid(valid_p), .i_ready(ready), .o_last(last_p),
        .o_busy(busy_p), .o_done(done_p), .o_overflow(ovf_p), .o_range_err(rng_p)
    );

    party_broadcast_packer #(.FIELD("GF256"), .PARAMETER_SET("L5")) u_gf256 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_alpha(alpha), .i_beta(beta), .i_v(v), .i_clear(clear),
        .o_data(data_g), .o_valid(valid_g), .i_ready(ready), .o_last(last_g),
        .o_busy(busy_g), .o_done(done_g), .o_overflow(ovf_g), .o_range_err(rng_g)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: the pending words of the current capture live in a
    // queue; a transfer pops the head, the capture ends when the queue empties.
    // ------------------------------------------------------------------------
    bit          m_busy = 1'b0;
    logic [31:0] m_q[$];
    bit          m_done = 1'b0;
    bit          m_ovf  = 1'b0;
    bit          m_rng  = 1'b0;
    int          m_hold = 0;
    bit          m_xfer, m_fin, m_acc, m_ovf_set, m_rng_set;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_q.delete();
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_rng  = 1'b0;
            m_hold = 2;          // two edges of synchronised reset release
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            m_xfer    = m_busy && ready;
            m_fin     = m_xfer && (m_q.size() == 1);
            if (m_xfer) void'(m_q.pop_front());
            m_acc     = start && (!m_busy || m_fin);
            m_ovf_set = start && m_busy && !m_fin;
            m_rng_set = 1'b0;
            if (m_acc) begin
                m_q.delete();
                for (int i = 0; i < T; i++) m_q.push_back(alpha[32*i +: 32]);
                for (int i = 0; i < T; i++) m_q.push_back(beta[32*i +: 32]);
                for (int i = 0; i < T; i++) m_q.push_back(v[32*i +: 32]);
                foreach (m_q[i]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (m_q[i][8*b +: 8] >= 8'd251) m_rng_set = 1'b1;
                    end
                end
                m_busy = 1'b1;
            end else if (m_fin) begin
                m_busy = 1'b0;
            end
            m_done = m_fin;
            m_ovf  = m_ovf_set || (m_ovf && !clear);
            m_rng  = m_rng_set || (m_rng && !clear);
        end
    end

    // ------------------------------------------------------------------------
    // Compare process: on every falling edge, check both instances against the
    // model and log accepted words (inputs are already set for the next edge).
    // ------------------------------------------------------------------------
    bit          cmp_en = 1'b0;
    logic [31:0] log_q[$];
    bit          last_log[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("p251 valid",    32'(valid_p), 32'(m_busy));
            check("p251 busy",     32'(busy_p),  32'(m_busy));
            check("p251 last",     32'(last_p),  32'(m_busy && (m_q.size() == 1)));
            check("p251 done",     32'(done_p),  32'(m_done));
            check("p251 overflow", 32'(ovf_p),   32'(m_ovf));
            check("p251 range",    32'(rng_p),   32'(m_rng));
            check("gf256 valid",   32'(valid_g), 32'(m_busy));
            check("gf256 last",    32'(last_g),  32'(m_busy && (m_q.size() == 1)));
            check("gf256 done",    32'(done_g),  32'(m_done));
            check("gf256 overflow",32'(ovf_g),   32'(m_ovf));
            check("gf256 range",   32'(rng_g),   32'd0);
            if (m_busy) begin
                check("p251 data",  data_p, m_q[0]);
                check("gf256 data", data_g, m_q[0]);
            end
            if (valid_p && ready) begin
                log_q.push_back(data_p);
                last_log.push_back(last_p);
            end
            if (done_p) done_cnt++;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_q.delete();
        last_log.delete();
        done_cnt = 0;
    endtask

    task automatic set_basic();
        alpha = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
        beta  = {32'h0000_0014, 32'h0000_0013, 32'h0000_0012, 32'h0000_0011};
        v     = {32'h0000_0024, 32'h0000_0023, 32'h0000_0022, 32'h0000_0021};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_p || done_p) && n < 200) begin
            tick();
            n++;
        end
        check({name, " finished in time"}, 32'(n < 200), 32'd1);
    endtask

    task automatic check_basic_log(input string tag);
        logic [31:0] exp_w [NW];
        exp_w = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h11, 32'h12,
                  32'h13, 32'h14, 32'h21, 32'h22, 32'h23, 32'h24};
        check({tag, " transfer count"}, 32'(log_q.size()), 32'd12);
        for (int i = 0; i < NW && i < log_q.size(); i++) begin
            check($sformatf("%s word%0d", tag, i), log_q[i], exp_w[i]);
            check($sformatf("%s last%0d", tag, i), 32'(last_log[i]), 32'(i == NW - 1));
        end
    endtask

    function automatic logic [32*T-1:0] rand_vec(input bit clean);
        logic [32*T-1:0] r;
        for (int i = 0; i < T; i++) begin
            r[32*i +: 32] = clean ? ($urandom() & 32'h7F7F_7F7F) : $urandom();
        end
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        // ---------------- reset ----------------
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid",    32'(valid_p), 32'd0);
        check("reset data",     data_p,       32'd0);
        check("reset busy",     32'(busy_p),  32'd0);
        check("reset done",     32'(done_p),  32'd0);
        check("reset last",     32'(last_p),  32'd0);
        check("reset overflow", 32'(ovf_p),   32'd0);
        check("reset range",    32'(rng_p),   32'd0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        repeat (4) tick();

        // ---------------- basic stream ----------------
        clear_log();
        ready = 1'b1;
        set_basic();
        pulse_start();
        check("basic first valid", 32'(valid_p), 32'd1);
        check("basic first data",  data_p,       32'h01);
        wait_idle("basic");
        check_basic_log("basic");
        check("basic done pulses", 32'(done_cnt), 32'd1);
        check("basic busy after",  32'(busy_p),   32'd0);

        // ---------------- backpressure ----------------
        clear_log();
        set_basic();
        pulse_start();
        for (int k = 0; k < 200 && (busy_p || done_p); k++) begin
            ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        ready = 1'b1;
        wait_idle("backpressure");
        check_basic_log("backpressure");
        check("backpressure done pulses", 32'(done_cnt), 32'd1);

        // ---------------- back-to-back ----------------
        clear_log();
        set_basic();
        pulse_start();
        repeat (11) tick();
        alpha[31:0] = 32'h0000_00AA;
        pulse_start();
        check("b2b next data", data_p,       32'h0000_00AA);
        check("b2b valid",     32'(valid_p), 32'd1);
        check("b2b done",      32'(done_p),  32'd1);
        check("b2b overflow",  32'(ovf_p),   32'd0);
        wait_idle("b2b");
        check("b2b transfer count", 32'(log_q.size()), 32'd24);
        if (log_q.size() == 24) begin
            check("b2b word11", log_q[11], 32'h24);
            check("b2b word12", log_q[12], 32'hAA);
        end
        check("b2b done pulses", 32'(done_cnt), 32'd2);

        // ---------------- overflow ----------------
        clear_log();
        set_basic();
        pulse_start();
        repeat (5) tick();
        check("ovf word5 shown", data_p, 32'h12);
        alpha = {T{32'h5555_5555}};
        beta  = {T{32'h5555_5555}};
        v     = {T{32'h5555_5555}};
        pulse_start();
        check("ovf flag",          32'(ovf_p), 32'd1);
        check("ovf stream intact", data_p,     32'h13);
        wait_idle("overflow");
        check_basic_log("overflow");
        check("ovf done pulses", 32'(done_cnt), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovf cleared", 32'(ovf_p), 32'd0);

        // ---------------- range ----------------
        clear_log();
        set_basic();
        beta[63:32] = 32'h00FB_0000;
        pulse_start();
        check("range p251",  32'(rng_p), 32'd1);
        check("range gf256", 32'(rng_g), 32'd0);
        wait_idle("range");
        check("range transfer count", 32'(log_q.size()), 32'd12);
        if (log_q.size() == 12) check("range word5 intact", log_q[5], 32'h00FB_0000);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("range cleared", 32'(rng_p), 32'd0);

        // ---------------- reset mid-stream ----------------
        set_basic();
        pulse_start();
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst valid p251", 32'(valid_p), 32'd0);
        check("rst busy p251",  32'(busy_p),  32'd0);
        check("rst done p251",  32'(done_p),  32'd0);
        check("rst valid gf256",32'(valid_g), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick();
        clear_log();
        set_basic();
        pulse_start();
        wait_idle("post-reset");
        check_basic_log("post-reset");
        check("post-reset done pulses", 32'(done_cnt), 32'd1);

        // ---------------- randomized ----------------
        for (int c = 0; c < 1500; c++) begin
            bit clean;
            clean = $urandom_range(0, 1) == 1;
            start = $urandom_range(0, 9) == 0;
            ready = $urandom_range(0, 3) != 0;
            clear = $urandom_range(0, 15) == 0;
            alpha = rand_vec(clean);
            beta  = rand_vec(clean);
            v     = rand_vec(clean);
            tick();
        end
        start = 1'b0;
        clear = 1'b0;
        ready = 1'b1;
        wait_idle("random drain");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
